// File: rtl/serial_csa_pkg.sv
// Shared types and helpers for the serial carry-skip adder.
package serial_csa_pkg;

    // Sequencer states: waiting for operands, adding one chunk per cycle, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the chunk index counter; at least one bit even for a single chunk.
    function automatic int idx_width(input int num_blocks);
        int w;
        w = $clog2(num_blocks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/carry_skip_block.sv
// One carry-skip adder chunk: ripple-carry sum with a bypass mux that forwards
// the incoming carry when every bit position propagates.
// block_carry_out is the plain ripple carry, before the skip mux.
module carry_skip_block #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             block_carry_out
);

    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH:0]   ripple;

    // Per-bit propagate and generate terms.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
            assign prop[gi] = a_i[gi] ^ b_i[gi];
            assign gen[gi]  = a_i[gi] & b_i[gi];
        end
    endgenerate

    // Ripple carry chain through the chunk, bit 0 upward.
    always_comb begin
        ripple    = '0;
        ripple[0] = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            ripple[i+1] = gen[i] | (prop[i] & ripple[i]);
        end
    end

    assign sum_o           = prop ^ ripple[WIDTH-1:0];
    assign block_carry_out = ripple[WIDTH];
    // When the whole chunk propagates, the carry out equals the carry in.
    assign cout_o          = (&prop) ? cin_i : ripple[WIDTH];

endmodule

// File: rtl/serial_carry_skip_adder.sv
// Multi-cycle wide adder that reuses one carry_skip_block across all chunks,
// LSB chunk first, with valid/ready handshakes on input and output.
// Optional macro SERIAL_CSA_SUB_EN adds a 'sub' input selecting a - b.
module serial_carry_skip_adder
    import serial_csa_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
`ifdef SERIAL_CSA_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  overflow
);

    localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;
    localparam int IDX_W      = idx_width(NUM_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    generate
        if ((BLOCK_WIDTH < 1) || (DATA_WIDTH % BLOCK_WIDTH != 0)) begin : g_param_check
            $error("serial_carry_skip_adder: DATA_WIDTH must be a non-zero multiple of BLOCK_WIDTH");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;

    logic [DATA_WIDTH-1:0]   b_eff;
    logic                    cin_eff;
    logic [BLOCK_WIDTH-1:0]  chunk_a;
    logic [BLOCK_WIDTH-1:0]  chunk_b;
    logic [BLOCK_WIDTH-1:0]  chunk_sum;
    logic                    chunk_cout;
    logic                    blk_carry_unused;

`ifdef SERIAL_CSA_SUB_EN
    logic sub_q, sub_d;
    // Subtract is a + ~b + 1, so the operand is inverted and the carry in forced high.
    assign b_eff   = sub_q ? ~b_q : b_q;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b_q;
    assign cin_eff = cin;
`endif

    // Current chunk of each operand, selected by the running index.
    assign chunk_a = a_q[int'(idx_q) * BLOCK_WIDTH +: BLOCK_WIDTH];
    assign chunk_b = b_eff[int'(idx_q) * BLOCK_WIDTH +: BLOCK_WIDTH];

    // Carry between chunks only travels through carry_q, never combinationally.
    carry_skip_block #(
        .WIDTH (BLOCK_WIDTH)
    ) u_csb (
        .a_i             (chunk_a),
        .b_i             (chunk_b),
        .cin_i           (carry_q),
        .sum_o           (chunk_sum),
        .cout_o          (chunk_cout),
        .block_carry_out (blk_carry_unused)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef SERIAL_CSA_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef SERIAL_CSA_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Next-state and handshake logic: accept in IDLE, one chunk per RUN cycle, hold in DONE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        a_d       = a_q;
        b_d       = b_q;
`ifdef SERIAL_CSA_SUB_EN
        sub_d     = sub_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin_eff;
`ifdef SERIAL_CSA_SUB_EN
                    sub_d   = sub;
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * BLOCK_WIDTH +: BLOCK_WIDTH] = chunk_sum;
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum      = sum_q;
    assign cout     = carry_q;
    // Signed overflow: operands of equal sign produced a result of the other sign.
    assign overflow = (a_q[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1])
                   && (sum_q[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);

endmodule

// File: tb/tb_serial_carry_skip_adder.sv
// Self-checking bench for serial_carry_skip_adder (16-bit, 4-bit chunks).
// Expected results are queued at the accept edge and compared when out_valid rises.
module tb_serial_carry_skip_adder;

    localparam int DW = 16;
    localparam int BW = 4;
    localparam int NB = DW / BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          cin = 1'b0;
`ifdef SERIAL_CSA_SUB_EN
    logic          sub = 1'b0;
`endif
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] sum;
    logic          cout;
    logic          overflow;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [DW-1:0] pa, pb;
    logic          pcin, psub;

    serial_carry_skip_adder #(
        .DATA_WIDTH  (DW),
        .BLOCK_WIDTH (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_CSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference adder: full-width sum with an extra carry bit.
    function automatic exp_t model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t          e;
        logic [DW-1:0] beff;
        logic          c0;
        logic [DW:0]   full;
        beff   = sv ? ~bv : bv;
        c0     = sv ? 1'b1 : cv;
        full   = {1'b0, av} + {1'b0, beff} + {{DW{1'b0}}, c0};
        e.a    = av;
        e.b    = bv;
        e.sum  = full[DW-1:0];
        e.cout = full[DW];
        e.ovf  = (av[DW-1] == beff[DW-1]) && (full[DW-1] != av[DW-1]);
        return e;
    endfunction

    // Put operands on the bus with in_valid high (called at a negedge).
    task automatic present_op(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                              input logic cv, input logic sv);
        pa = av; pb = bv; pcin = cv; psub = sv;
        a = av; b = bv; cin = cv;
`ifdef SERIAL_CSA_SUB_EN
        sub = sv;
`endif
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for in_ready, take the accept edge, queue the expectation,
    // then drop in_valid and scramble the operands.
    task automatic accept_op();
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        sb_q.push_back(model(pa, pb, pcin, psub));
        @(negedge clk);
        in_valid = 1'b0;
        a = DW'($urandom);
        b = DW'($urandom);
        cin = 1'(~pcin);
    endtask

    // Wait (bounded) for out_valid, check latency and result; optionally release it.
    task automatic wait_result(input bit hold);
        int   w = 0;
        exp_t e;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("latency", 32'(cyc - accept_cyc), 32'(NB));
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        last_exp = e;
        check("sum", {16'd0, sum}, {16'd0, e.sum});
        check("cout", {31'd0, cout}, {31'd0, e.cout});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        $display("txn a=%04h b=%04h sum=%04h cout=%0b ovf=%0b", e.a, e.b, sum, cout, overflow);
        if (!hold) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("release_out_valid", {31'd0, out_valid}, 32'd0);
            check("release_in_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                          input logic cv, input logic sv);
        @(negedge clk);
        present_op(av, bv, cv, sv);
        accept_op();
        wait_result(1'b0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        // Directed additions.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

        // Backpressure: result held while new operands wait on the bus.
        @(negedge clk);
        present_op(16'h0ABC, 16'h1111, 1'b1, 1'b0);
        accept_op();
        wait_result(1'b1);
        present_op(16'h5A5A, 16'hA5A5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum", {16'd0, sum}, {16'd0, last_exp.sum});
            check("bp_cout", {31'd0, cout}, {31'd0, last_exp.cout});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        accept_op();
        wait_result(1'b0);

        // Asynchronous reset pulse in RUN at idx=2.
        @(negedge clk);
        present_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        accept_op();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        #1 rst_n = 1'b1;
        void'(sb_q.pop_back());
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

`ifdef SERIAL_CSA_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
`endif

        // Random operands.
        for (int i = 0; i < 6; i++) begin
            run_op(DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
